// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass, pending-write scoreboard and post-reset clear sweep.
// Latency: reads are combinational (0 cycles); writes and scoreboard updates take effect on the next rising edge.
// Backpressure: none on the ports; ready stays low during the 2**ADDR_W-cycle clear sweep, and inputs are ignored until it rises.
`timescale 1ns/1ps
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_WR-1:0]        we,
    input  logic [NUM_WR*ADDR_W-1:0] waddr,
    input  logic [NUM_WR*DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    output logic [NUM_RD-1:0]        rpend,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_addr,
    output logic                     ready
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_idx;
    logic [ADDR_W-1:0]   clr_idx_nxt;
    logic                run;

    logic [DATA_W-1:0]   regs [DEPTH];
    logic [DEPTH-1:0]    pending;
    logic [DEPTH-1:0]    pending_nxt;

    // Unpacked views of the write ports.
    logic [ADDR_W-1:0]   waddr_p [NUM_WR];
    logic [DATA_W-1:0]   wdata_p [NUM_WR];
    logic [NUM_WR-1:0]   wr_live;   // write port active while the file is running
    logic [NUM_WR-1:0]   wr_store;  // write actually lands in storage (register 0 excluded when hardwired)

    // Set-pending request after removing the hardwired-zero destination.
    logic                sb_live;

    assign run   = (state == RUN);
    assign ready = run;

    for (genvar i = 0; i < NUM_WR; i++) begin : g_wr_unpack
        assign waddr_p[i]  = waddr[i*ADDR_W +: ADDR_W];
        assign wdata_p[i]  = wdata[i*DATA_W +: DATA_W];
        assign wr_live[i]  = run & we[i];
        assign wr_store[i] = wr_live[i] & ~((ZERO_REG != 0) && (waddr_p[i] == '0));
    end

    assign sb_live = run & sb_set & ~((ZERO_REG != 0) && (sb_addr == '0));

    // State register: reset restarts the clear sweep from entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next state: step through every entry once, then run.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        if (state == CLEAR) begin
            clr_idx_nxt = clr_idx + ADDR_W'(1);
            if (clr_idx == LAST_IDX) begin
                state_nxt = RUN;
            end
        end
    end

    // Storage: sweep writes zeros; in RUN the later (higher) port overrides on address collisions.
    always_ff @(posedge clk) begin
        if (!run) begin
            regs[clr_idx] <= '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_store[i]) begin
                    regs[waddr_p[i]] <= wdata_p[i];
                end
            end
        end
    end

    // Scoreboard update: retiring writes clear, then a new issue sets (set wins on the same address).
    always_comb begin
        pending_nxt = pending;
        if (!run) begin
            pending_nxt = '0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_live[i]) begin
                    pending_nxt[waddr_p[i]] = 1'b0;
                end
            end
            if (sb_live) begin
                pending_nxt[sb_addr] = 1'b1;
            end
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // Read ports: disabled/zero-register reads return 0, same-cycle writes bypass storage.
    always_comb begin : read_path
        logic [ADDR_W-1:0] ra;
        logic              hit;
        logic [DATA_W-1:0] byp;
        rdata = '0;
        rpend = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            ra  = raddr[j*ADDR_W +: ADDR_W];
            hit = 1'b0;
            byp = '0;
            for (int i = 0; i < NUM_WR; i++) begin
                if (wr_live[i] && (waddr_p[i] == ra)) begin
                    hit = 1'b1;
                    byp = wdata_p[i];
                end
            end
            if (run && re[j] && !((ZERO_REG != 0) && (ra == '0))) begin
                rdata[j*DATA_W +: DATA_W] = hit ? byp : regs[ra];
                rpend[j]                  = pending[ra] & ~hit;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus pushes expected outputs, a negedge monitor pops and compares.
// Latency: expectations are checked in the same cycle they are issued (combinational reads).
// Backpressure: none; the bench counts fixed sweep cycles and a watchdog bounds the whole run.
`timescale 1ns/1ps
module tb_regfile_mp;

    localparam int K_RDY = 0;
    localparam int K_RD0 = 1;
    localparam int K_PD0 = 2;
    localparam int K_RD1 = 3;
    localparam int K_PD1 = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [1:0]  re;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rpend;
    logic        sb_set;
    logic [4:0]  sb_addr;
    logic        ready;

    int          q_kind [$];
    logic [31:0] q_val  [$];
    string       q_name [$];

    int n_total = 0;
    int n_pass  = 0;

    regfile_mp dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re      (re),
        .raddr   (raddr),
        .rdata   (rdata),
        .rpend   (rpend),
        .sb_set  (sb_set),
        .sb_addr (sb_addr),
        .ready   (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input int kind, input logic [31:0] val, input string name);
        q_kind.push_back(kind);
        q_val.push_back(val);
        q_name.push_back(name);
    endtask

    task automatic set_rd(input int p, input logic en, input logic [4:0] a);
        re[p]          = en;
        raddr[p*5 +: 5] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [4:0] a, input logic [31:0] d);
        we[p]            = en;
        waddr[p*5 +: 5]  = a;
        wdata[p*32 +: 32] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        we     = '0;
        re     = '0;
        sb_set = 1'b0;
    endtask

    // Sweep starting in the current cycle: 32 cycles of ready=0 with ignored junk traffic, then ready=1.
    task automatic check_sweep();
        for (int c = 0; c < 32; c++) begin
            set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
            set_wr(1, 1'b1, 5'd6, 32'hCAFE_F00D);
            sb_set  = 1'b1;
            sb_addr = 5'd6;
            set_rd(0, 1'b1, 5'd5);
            set_rd(1, 1'b1, 5'd6);
            push_exp(K_RDY, 32'd0, "sweep_ready_low");
            push_exp(K_RD0, 32'd0, "sweep_rdata0");
            push_exp(K_RD1, 32'd0, "sweep_rdata1");
            push_exp(K_PD1, 32'd0, "sweep_rpend1");
            next_cycle();
        end
        push_exp(K_RDY, 32'd1, "sweep_ready_high");
    endtask

    // Monitor: compare every queued expectation against the outputs away from the active edge.
    always @(negedge clk) begin
        int          k;
        logic [31:0] v;
        logic [31:0] act;
        string       n;
        while (q_kind.size() > 0) begin
            k = q_kind.pop_front();
            v = q_val.pop_front();
            n = q_name.pop_front();
            case (k)
                K_RDY:   act = {31'b0, ready};
                K_RD0:   act = rdata[31:0];
                K_PD0:   act = {31'b0, rpend[0]};
                K_RD1:   act = rdata[63:32];
                K_PD1:   act = {31'b0, rpend[1]};
                default: act = 'x;
            endcase
            n_total++;
            if (act === v) n_pass++;
            else $display("FAIL %s: got 0x%0h, required 0x%0h", n, act, v);
        end
    end

    initial begin
        rst     = 1'b0;
        we      = '0;
        waddr   = '0;
        wdata   = '0;
        re      = '0;
        raddr   = '0;
        sb_set  = 1'b0;
        sb_addr = '0;

        // Reset state
        next_cycle();
        next_cycle();
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd31);
        push_exp(K_RDY, 32'd0, "reset_ready");
        push_exp(K_RD0, 32'd0, "reset_rdata0");
        push_exp(K_PD0, 32'd0, "reset_rpend0");
        push_exp(K_RD1, 32'd0, "reset_rdata1");

        // Release reset and run the initial clear sweep
        next_cycle();
        rst = 1'b1;
        check_sweep();
        #1;
        n_total++;
        if (ready === 1'b1) n_pass++;
        else $display("FAIL direct_ready_after_sweep: got %b, required 1", ready);

        // Every entry reads zero and nothing is pending after the sweep
        for (int a = 0; a < 32; a++) begin
            next_cycle();
            set_rd(0, 1'b1, 5'(a));
            set_rd(1, 1'b1, 5'(31 - a));
            push_exp(K_RD0, 32'd0, "clear_rdata0");
            push_exp(K_PD0, 32'd0, "clear_rpend0");
            push_exp(K_RD1, 32'd0, "clear_rdata1");
            push_exp(K_PD1, 32'd0, "clear_rpend1");
        end

        // Same-address collision: port 1 wins, bypass returns it, disabled read port returns 0
        next_cycle();
        set_wr(0, 1'b1, 5'd5, 32'h11);
        set_wr(1, 1'b1, 5'd5, 32'h22);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b0, 5'd5);
        push_exp(K_RD0, 32'h22, "collide_bypass");
        push_exp(K_PD0, 32'd0,  "collide_rpend");
        push_exp(K_RD1, 32'd0,  "read_disabled");
        next_cycle();
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd5);
        push_exp(K_RD0, 32'h22, "collide_stored0");
        push_exp(K_RD1, 32'h22, "collide_stored1");

        // Single-port write with bypass on the other read port
        next_cycle();
        set_wr(0, 1'b1, 5'd8, 32'h88);
        set_rd(0, 1'b1, 5'd5);
        set_rd(1, 1'b1, 5'd8);
        push_exp(K_RD0, 32'h22, "r5_held");
        push_exp(K_RD1, 32'h88, "r8_bypass");
        next_cycle();
        set_rd(1, 1'b1, 5'd8);
        push_exp(K_RD1, 32'h88, "r8_stored");

        // Register 0 is hardwired to zero and never pending
        next_cycle();
        set_wr(1, 1'b1, 5'd0, 32'hFFFF_FFFF);
        set_rd(0, 1'b1, 5'd0);
        push_exp(K_RD0, 32'd0, "r0_no_bypass");
        next_cycle();
        sb_set  = 1'b1;
        sb_addr = 5'd0;
        set_rd(0, 1'b1, 5'd0);
        push_exp(K_RD0, 32'd0, "r0_write_dropped");
        next_cycle();
        set_rd(0, 1'b1, 5'd0);
        push_exp(K_RD0, 32'd0, "r0_rdata");
        push_exp(K_PD0, 32'd0, "r0_never_pending");

        // Pending set by issue, resolved by writeback through the bypass
        next_cycle();
        sb_set  = 1'b1;
        sb_addr = 5'd7;
        set_rd(0, 1'b1, 5'd7);
        push_exp(K_PD0, 32'd0, "r7_pending_not_yet");
        next_cycle();
        set_rd(0, 1'b1, 5'd7);
        set_rd(1, 1'b0, 5'd7);
        push_exp(K_PD0, 32'd1, "r7_pending");
        push_exp(K_RD0, 32'd0, "r7_old_value");
        push_exp(K_PD1, 32'd0, "r7_rpend_re_off");
        next_cycle();
        set_wr(0, 1'b1, 5'd7, 32'hABCD);
        set_rd(0, 1'b1, 5'd7);
        push_exp(K_PD0, 32'd0,    "r7_wb_rpend");
        push_exp(K_RD0, 32'hABCD, "r7_wb_bypass");
        #1;
        n_total++;
        if (rdata[31:0] === 32'hABCD) n_pass++;
        else $display("FAIL direct_r7_wb_bypass: got 0x%0h, required 0xabcd", rdata[31:0]);
        n_total++;
        if (rpend[0] === 1'b0) n_pass++;
        else $display("FAIL direct_r7_wb_rpend: got %b, required 0", rpend[0]);
        next_cycle();
        set_rd(0, 1'b1, 5'd7);
        push_exp(K_PD0, 32'd0,    "r7_after_rpend");
        push_exp(K_RD0, 32'hABCD, "r7_after_rdata");

        // Set and retire on the same address in one cycle: set wins
        next_cycle();
        sb_set  = 1'b1;
        sb_addr = 5'd9;
        set_wr(1, 1'b1, 5'd9, 32'h99);
        set_rd(1, 1'b1, 5'd9);
        push_exp(K_RD1, 32'h99, "r9_bypass");
        push_exp(K_PD1, 32'd0,  "r9_rpend_same");
        next_cycle();
        set_rd(1, 1'b1, 5'd9);
        push_exp(K_PD1, 32'd1,  "r9_set_wins");
        push_exp(K_RD1, 32'h99, "r9_stored");
        #1;
        n_total++;
        if (rpend[1] === 1'b1) n_pass++;
        else $display("FAIL direct_r9_set_wins: got %b, required 1", rpend[1]);
        next_cycle();
        set_wr(0, 1'b1, 5'd9, 32'h9A);
        set_rd(1, 1'b1, 5'd9);
        push_exp(K_RD1, 32'h9A, "r9_second_wb");
        push_exp(K_PD1, 32'd0,  "r9_second_rpend");
        next_cycle();
        set_rd(1, 1'b1, 5'd9);
        push_exp(K_PD1, 32'd0,  "r9_cleared");

        // Reset mid-RUN, then again mid-sweep at clr_idx=10
        next_cycle();
        set_wr(0, 1'b1, 5'd3, 32'h55);
        next_cycle();
        set_rd(0, 1'b1, 5'd3);
        push_exp(K_RD0, 32'h55, "r3_stored");
        push_exp(K_RDY, 32'd1,  "run_ready");
        next_cycle();
        rst = 1'b0;
        set_rd(0, 1'b1, 5'd3);
        push_exp(K_RDY, 32'd0, "rst_run_ready");
        push_exp(K_RD0, 32'd0, "rst_run_rdata");
        next_cycle();
        rst = 1'b1;
        push_exp(K_RDY, 32'd0, "resweep_ready");
        repeat (10) next_cycle();
        rst = 1'b0;
        push_exp(K_RDY, 32'd0, "rst_sweep_ready");
        next_cycle();
        rst = 1'b1;
        check_sweep();
        next_cycle();
        set_rd(0, 1'b1, 5'd3);
        set_rd(1, 1'b1, 5'd5);
        push_exp(K_RD0, 32'd0, "r3_after_sweep");
        push_exp(K_PD0, 32'd0, "r3_after_rpend");
        push_exp(K_RD1, 32'd0, "r5_after_sweep");

        next_cycle();
        @(negedge clk);
        @(negedge clk);
        while (q_kind.size() > 0) begin
            n_total++;
            $display("FAIL unchecked_%s: got none, required one comparison", q_name.pop_front());
            void'(q_kind.pop_front());
            void'(q_val.pop_front());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
